reg_writeback: RTL and testbench

Writeback stage sitting between the execution units and the register file write port. It accepts destination-register results from two producers (ALU channel and load/memory channel), buffers each in its own small FIFO, arbitrates between them, and issues at most one registered write per cycle as `rf_we`/`rf_addr`/`rf_wdata`. Writes to register 0 are accepted and discarded, matching the register file's hardwired-zero read behaviour.

---
 rtl/reg_writeback_pkg.sv | 17 +
 rtl/reg_writeback_if.sv | 48 ++++
 rtl/reg_writeback_wb_fifo.sv | 67 ++++++
 rtl/reg_writeback.sv | 144 ++++++++++++++
 tb/tb_reg_writeback.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared types and widths for the register writeback stage.
//   REG_ADDR_W : register index width
//   XLEN       : register data width
//   NUM_REGS   : architectural register count (width of the pending vector)
//   wb_entry_t : one queued register write {rd, data}
package reg_writeback_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Bus bundle for reg_writeback: two producer channels (ALU, memory) with
// valid/ready handshakes and the register-file write port.
//   master : producer / register-file side (drives valid, rd, data)
//   slave  : the writeback stage (drives ready and the rf_* write port)
// Optional: REG_WB_PENDING_EN adds the 32-bit pending scoreboard output.
interface reg_writeback_if;
    import reg_writeback_pkg::*;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_addr;
    logic [XLEN-1:0]       rf_wdata;
`ifdef REG_WB_PENDING_EN
    logic [NUM_REGS-1:0]   pending;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
`ifdef REG_WB_PENDING_EN
        input  pending,
`endif
        input  rf_we, rf_addr, rf_wdata
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
`ifdef REG_WB_PENDING_EN
        output pending,
`endif
        output rf_we, rf_addr, rf_wdata
    );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// wb_fifo: small synchronous FIFO of wb_entry_t used per producer channel.
//   clk, rst_n : clock, async active-low reset
//   push       : enqueue wr_entry (caller guarantees !full)
//   pop        : dequeue head (caller guarantees !empty)
//   head       : oldest entry, valid while !empty
//   full       : registered; high during reset and whenever occupancy == DEPTH
//   empty      : occupancy == 0
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wr_entry,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // Next occupancy; full is derived from it so it is a plain register.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and full flag; full reads high in reset so no
    // producer sees space until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    // Payload storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= wr_entry;
    end

    assign head  = slots[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: buffers ALU and load results in per-channel FIFOs, arbitrates
// between them (memory preferred, ALU forced after STARVE_LIMIT consecutive
// memory grants) and issues at most one registered register-file write per
// cycle. Writes to register 0 complete the handshake but are dropped.
//   CLK, RSTN : clock, async active-low reset
//   bus       : reg_writeback_if.slave (channel handshakes + rf write port)
// Parameters: DEPTH (per-channel FIFO entries, power of two >= 2),
//             STARVE_LIMIT (>= 1).
// Optional: REG_WB_PENDING_EN enables the pending-register vector.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic           CLK,
    input  logic           RSTN,
    reg_writeback_if.slave bus
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t alu_in;
    wb_entry_t mem_in;
    wb_entry_t alu_head;
    wb_entry_t mem_head;
    logic      alu_push;
    logic      mem_push;
    logic      alu_pop;
    logic      mem_pop;
    logic      alu_full;
    logic      mem_full;
    logic      alu_empty;
    logic      mem_empty;

    logic [STARVE_W-1:0]   starve_q;
    logic [STARVE_W-1:0]   starve_nxt;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_addr_q;
    logic [XLEN-1:0]       rf_wdata_q;

    // Handshake: ready comes straight from the registered full flag.
    assign bus.alu_ready = !alu_full;
    assign bus.mem_ready = !mem_full;

    assign alu_in = '{rd: bus.alu_rd, data: bus.alu_data};
    assign mem_in = '{rd: bus.mem_rd, data: bus.mem_data};

    // rd == 0 transfers are acknowledged but never enqueued.
    assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
    assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_rd != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk      (CLK),
        .rst_n    (RSTN),
        .push     (alu_push),
        .pop      (alu_pop),
        .wr_entry (alu_in),
        .head     (alu_head),
        .full     (alu_full),
        .empty    (alu_empty)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk      (CLK),
        .rst_n    (RSTN),
        .push     (mem_push),
        .pop      (mem_pop),
        .wr_entry (mem_in),
        .head     (mem_head),
        .full     (mem_full),
        .empty    (mem_empty)
    );

    // Arbitration and starve-counter update.
    always_comb begin
        alu_pop    = 1'b0;
        mem_pop    = 1'b0;
        starve_nxt = starve_q;

        if (!alu_empty && !mem_empty) begin
            if (starve_q == STARVE_W'(STARVE_LIMIT)) alu_pop = 1'b1;
            else                                     mem_pop = 1'b1;
        end else if (!alu_empty) begin
            alu_pop = 1'b1;
        end else if (!mem_empty) begin
            mem_pop = 1'b1;
        end

        if (alu_empty || alu_pop) begin
            starve_nxt = '0;
        end else if (mem_pop && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_nxt = starve_q + STARVE_W'(1);
        end
    end

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            starve_q   <= '0;
        end else begin
            rf_we_q  <= alu_pop || mem_pop;
            starve_q <= starve_nxt;
            if (alu_pop) begin
                rf_addr_q  <= alu_head.rd;
                rf_wdata_q <= alu_head.data;
            end else if (mem_pop) begin
                rf_addr_q  <= mem_head.rd;
                rf_wdata_q <= mem_head.data;
            end
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wdata = rf_wdata_q;

`ifdef REG_WB_PENDING_EN
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pend_set;
    logic [NUM_REGS-1:0] pend_clr;

    // Set on acceptance, clear once the write cycle has completed.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (alu_push) pend_set[bus.alu_rd] = 1'b1;
        if (mem_push) pend_set[bus.mem_rd] = 1'b1;
        if (rf_we_q)  pend_clr[rf_addr_q]  = 1'b1;
    end

    // Set wins over a same-cycle clear of the same register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) pending_q <= '0;
        else       pending_q <= (pending_q & ~pend_clr) | pend_set;
    end

    assign bus.pending = pending_q;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback. Stimulus queues feed the two
// channels; accepted entries go to per-channel expected queues and are
// popped/compared when rf_we is seen. ALU traffic uses rd 1..15, memory
// traffic rd 16..31, so the write address identifies the channel.
// Optional: REG_WB_PENDING_EN enables the pending-vector checks.
module tb_reg_writeback;
    import reg_writeback_pkg::*;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 3;

    typedef struct {
        wb_entry_t e;
        int        cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    reg_writeback_if bus ();

    reg_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK  (clk),
        .RSTN (rst_n),
        .bus  (bus)
    );

    wb_entry_t alu_stim[$];
    wb_entry_t mem_stim[$];
    exp_t      exp_alu[$];
    exp_t      exp_mem[$];
    bit        glog[$];          // 1 = memory grant, 0 = ALU grant

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_alu_hs = 0;
    int n_mem_hs = 0;
    int n_alu_wr = 0;
    int n_mem_wr = 0;
    int n_unexp  = 0;
    bit drv_en   = 1'b0;
    bit lat_chk  = 1'b0;
    bit alu_hs   = 1'b0;
    bit mem_hs   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Channel driver. ready is registered, so its value at the falling edge
    // holds through the next rising edge and predicts the handshake.
    wb_entry_t drv_e;
    exp_t      drv_x;
    always @(negedge clk) begin
        if (!drv_en) begin
            alu_hs        = 1'b0;
            mem_hs        = 1'b0;
            bus.alu_valid = 1'b0;
            bus.mem_valid = 1'b0;
            bus.alu_rd    = '0;
            bus.mem_rd    = '0;
            bus.alu_data  = '0;
            bus.mem_data  = '0;
        end else begin
            if (alu_hs) begin
                drv_e = alu_stim.pop_front();
                n_alu_hs++;
                if (drv_e.rd != '0) begin
                    drv_x.e   = drv_e;
                    drv_x.cyc = cyc;
                    exp_alu.push_back(drv_x);
                end
            end
            if (mem_hs) begin
                drv_e = mem_stim.pop_front();
                n_mem_hs++;
                if (drv_e.rd != '0) begin
                    drv_x.e   = drv_e;
                    drv_x.cyc = cyc;
                    exp_mem.push_back(drv_x);
                end
            end
            bus.alu_valid = (alu_stim.size() != 0);
            if (bus.alu_valid) begin
                bus.alu_rd   = alu_stim[0].rd;
                bus.alu_data = alu_stim[0].data;
            end
            bus.mem_valid = (mem_stim.size() != 0);
            if (bus.mem_valid) begin
                bus.mem_rd   = mem_stim[0].rd;
                bus.mem_data = mem_stim[0].data;
            end
            alu_hs = bus.alu_valid && bus.alu_ready;
            mem_hs = bus.mem_valid && bus.mem_ready;
        end
    end

    // Write-port monitor / scoreboard.
    exp_t mon_x;
    always @(negedge clk) begin
        if (rst_n && bus.rf_we) begin
            if (bus.rf_addr[4]) begin
                glog.push_back(1'b1);
                n_mem_wr++;
                if (exp_mem.size() == 0) begin
                    n_unexp++;
                end else begin
                    mon_x = exp_mem.pop_front();
                    check("mem_addr", 32'(bus.rf_addr), 32'(mon_x.e.rd));
                    check("mem_data", bus.rf_wdata, mon_x.e.data);
                end
            end else begin
                glog.push_back(1'b0);
                n_alu_wr++;
                if (exp_alu.size() == 0) begin
                    n_unexp++;
                end else begin
                    mon_x = exp_alu.pop_front();
                    check("alu_addr", 32'(bus.rf_addr), 32'(mon_x.e.rd));
                    check("alu_data", bus.rf_wdata, mon_x.e.data);
                    // one further rising edge between acceptance and rf_we
                    if (lat_chk) check("alu_latency_edges", 32'(cyc - mon_x.cyc), 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (alu_stim.size() == 0) && (mem_stim.size() == 0) &&
                   (exp_alu.size() == 0) && (exp_mem.size() == 0);
        end
        check({tag, "_drained"}, 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_ready"}, 32'(bus.alu_ready), 32'd0);
        check({tag, "_mem_ready"}, 32'(bus.mem_ready), 32'd0);
        check({tag, "_rf_we"},     32'(bus.rf_we),     32'd0);
        check({tag, "_rf_addr"},   32'(bus.rf_addr),   32'd0);
        check({tag, "_rf_wdata"},  bus.rf_wdata,       32'd0);
`ifdef REG_WB_PENDING_EN
        check({tag, "_pending"},   bus.pending,        32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int        w0;
        int        h0a;
        int        h0m;
        int        a0;
        bit        found;
        wb_entry_t e;

        // Reset state
        #12;
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        check("release_alu_ready_pre_edge", 32'(bus.alu_ready), 32'd0);
        tick();
        check("release_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("release_mem_ready", 32'(bus.mem_ready), 32'd1);
        drv_en = 1'b1;

        // Single ALU write, latency and one-cycle rf_we
        lat_chk = 1'b1;
        e = '{rd: 5'd5, data: 32'hDEAD_BEEF};
        alu_stim.push_back(e);
        wait_idle("single", 20);
        check("single_rf_we",    32'(bus.rf_we),   32'd1);
        check("single_rf_addr",  32'(bus.rf_addr), 32'd5);
        check("single_rf_wdata", bus.rf_wdata,     32'hDEAD_BEEF);
        tick();
        check("single_rf_we_drop", 32'(bus.rf_we),   32'd0);
        check("idle_hold_addr",    32'(bus.rf_addr), 32'd5);
        check("idle_hold_wdata",   bus.rf_wdata,     32'hDEAD_BEEF);
        lat_chk = 1'b0;

        // rd = 0 on both channels: handshake completes, no write
        w0  = n_alu_wr + n_mem_wr;
        h0a = n_alu_hs;
        h0m = n_mem_hs;
        e = '{rd: 5'd0, data: 32'h1111_1111};
        alu_stim.push_back(e);
        e = '{rd: 5'd0, data: 32'h2222_2222};
        mem_stim.push_back(e);
        repeat (6) tick();
        check("rd0_alu_handshake", 32'(n_alu_hs - h0a), 32'd1);
        check("rd0_mem_handshake", 32'(n_mem_hs - h0m), 32'd1);
        check("rd0_no_write", 32'(n_alu_wr + n_mem_wr - w0), 32'd0);

        // Both channels streaming: M,M,M,A grant pattern
        glog.delete();
        for (int i = 0; i < 8; i++) begin
            e = '{rd: 5'(1 + i), data: $urandom()};
            alu_stim.push_back(e);
        end
        for (int i = 0; i < 12; i++) begin
            e = '{rd: 5'(16 + i), data: $urandom()};
            mem_stim.push_back(e);
        end
        wait_idle("stream", 200);
        check("stream_grant_count", 32'(glog.size()), 32'd20);
        for (int i = 0; i < 16 && i < glog.size(); i++) begin
            check($sformatf("stream_grant_%0d", i), 32'(glog[i]),
                  ((i % 4) == 3) ? 32'd0 : 32'd1);
        end

        // ALU FIFO fills behind memory traffic; fifth entry waits for a pop
        a0  = n_alu_wr;
        h0a = n_alu_hs;
        for (int i = 0; i < 20; i++) begin
            e = '{rd: 5'(16 + (i % 16)), data: $urandom()};
            mem_stim.push_back(e);
        end
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            e = '{rd: 5'(1 + i), data: $urandom()};
            alu_stim.push_back(e);
        end
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (bus.alu_valid && !bus.alu_ready) found = 1'b1;
        end
        check("alu_full_seen", 32'(found), 32'd1);
        check("alu_full_occupancy", 32'((n_alu_hs - h0a) - (n_alu_wr - a0)), 32'(DEPTH));
        wait_idle("full", 300);
        check("full_alu_delivered", 32'(n_alu_wr - a0), 32'd5);

        // Reset in the middle of traffic
        for (int i = 0; i < 4; i++) begin
            e = '{rd: 5'(20 + i), data: $urandom()};
            mem_stim.push_back(e);
        end
        for (int i = 0; i < 3; i++) begin
            e = '{rd: 5'(9 + i), data: $urandom()};
            alu_stim.push_back(e);
        end
        repeat (2) tick();
        #2;
        rst_n  = 1'b0;
        drv_en = 1'b0;
        #1;
        check_reset_outputs("midreset");
        alu_stim.delete();
        mem_stim.delete();
        exp_alu.delete();
        exp_mem.delete();
        w0 = n_alu_wr + n_mem_wr;
        repeat (2) tick();
        rst_n  = 1'b1;
        drv_en = 1'b1;
        repeat (8) tick();
        check("post_reset_no_write", 32'(n_alu_wr + n_mem_wr - w0), 32'd0);
        check("post_reset_alu_ready", 32'(bus.alu_ready), 32'd1);

`ifdef REG_WB_PENDING_EN
        // Pending bit lifetime for rd = 7
        h0a = n_alu_hs;
        e = '{rd: 5'd7, data: 32'h0000_0777};
        alu_stim.push_back(e);
        for (int k = 0; k < 10 && n_alu_hs == h0a; k++) tick();
        check("pend_set", bus.pending, 32'h0000_0080);
        tick();
        check("pend_we_cycle_rf_we", 32'(bus.rf_we), 32'd1);
        check("pend_we_cycle_bit", 32'(bus.pending[7]), 32'd1);
        tick();
        check("pend_cleared", bus.pending, 32'd0);
        wait_idle("pend", 20);
`endif

        check("unexpected_writes", 32'(n_unexp), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
